// File: rtl/sram_read_port.sv
// sram_read_port: read-side controller for a 16-bit asynchronous SRAM.
// Serves 32-bit word requests by reading the aligned halfword pair (low
// halfword first). One pending request can queue behind the word in flight.
// Optional build macro SRAM_READ_REG_EN registers sram_dq before capture,
// which adds one cycle to every halfword phase.
module sram_read_port #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        data_r_req,
    input  logic [21:1] data_r_address,
    output logic [31:0] data_r,
    output logic        data_r_empty,
    output logic        data_r_done,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [21:1] sram_a,
    input  logic [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI} state_t;

    logic [15:0] w_dq;

`ifdef SRAM_READ_REG_EN
    localparam int PH = WAIT_CYCLES + 2;

    logic [15:0] r_dq_q;

    // Register the SRAM data bus every cycle; captures use the registered copy.
    always_ff @(posedge CLK) begin
        r_dq_q <= sram_dq;
    end

    assign w_dq = r_dq_q;
`else
    localparam int PH = WAIT_CYCLES + 1;

    assign w_dq = sram_dq;
`endif

    localparam logic [4:0] LAST = 5'(PH - 1);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [21:2] r_addr;
    logic        r_pend_vld;
    logic [21:2] r_pend_addr;
    logic [15:0] r_lo;
    logic [31:0] r_data;
    logic        r_empty;
    logic        r_done;
    logic        r_overrun;
    logic [21:1] r_sram_a;
    logic        r_strobe_n;

    logic        w_busy;
    logic        w_last;
    logic        w_complete;
    logic        w_start_idle;
    logic        w_take_pend;
    logic        w_take_req;
    logic        w_start;
    logic [21:2] w_next_addr;
    logic        w_to_pend;
    logic        w_ovr_set;
    logic        w_unused_a1;

    // Bit 1 of the request address selects a halfword inside the word; the
    // word always covers the aligned pair, so it is deliberately dropped.
    assign w_unused_a1  = data_r_address[1];

    assign w_busy       = (r_state != IDLE);
    assign w_last       = (r_cnt == LAST);
    assign w_complete   = (r_state == RD_HI) && w_last;

    // Next-word selection: pending slot beats a fresh request at completion.
    assign w_start_idle = (r_state == IDLE) && data_r_req;
    assign w_take_pend  = w_complete && r_pend_vld;
    assign w_take_req   = w_complete && !r_pend_vld && data_r_req;
    assign w_start      = w_start_idle || w_take_pend || w_take_req;
    assign w_next_addr  = w_take_pend ? r_pend_addr : data_r_address[21:2];

    // A busy-time request lands in the pending slot unless it is consumed
    // directly at a completion with an empty slot.
    assign w_to_pend    = data_r_req && w_busy && !(w_complete && !r_pend_vld);
    assign w_ovr_set    = data_r_req && w_busy && !w_complete && r_pend_vld;

    // Control FSM with registered SRAM strobes, address and read-side outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_data     <= '0;
            r_empty    <= 1'b1;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_sram_a   <= '0;
            r_strobe_n <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state    <= RD_LO;
                r_cnt      <= '0;
                r_sram_a   <= {w_next_addr, 1'b0};
                r_strobe_n <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                    end
                    RD_LO: begin
                        if (w_last) begin
                            r_state  <= RD_HI;
                            r_cnt    <= '0;
                            r_sram_a <= {r_addr, 1'b1};
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    RD_HI: begin
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_strobe_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_strobe_n <= 1'b1;
                    end
                endcase
            end

            if (w_complete) begin
                r_data  <= {w_dq, r_lo};
                r_empty <= 1'b0;
                r_done  <= 1'b1;
            end

            if (w_to_pend) begin
                r_pend_vld <= 1'b1;
            end else if (w_take_pend) begin
                r_pend_vld <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Word address in flight, pending address and low-halfword capture.
    always_ff @(posedge CLK) begin
        if (w_start) begin
            r_addr <= w_next_addr;
        end
        if (w_to_pend) begin
            r_pend_addr <= data_r_address[21:2];
        end
        if ((r_state == RD_LO) && w_last) begin
            r_lo <= w_dq;
        end
    end

    assign data_r       = r_data;
    assign data_r_empty = r_empty;
    assign data_r_done  = r_done;
    assign overrun      = r_overrun;
    assign sram_a       = r_sram_a;
    assign sram_ce_n    = r_strobe_n;
    assign sram_oe_n    = r_strobe_n;
    assign sram_lb_n    = r_strobe_n;
    assign sram_ub_n    = r_strobe_n;
    assign sram_we_n    = 1'b1;

endmodule

// File: tb/tb_sram_read_port.sv
// tb_sram_read_port: two instances (WAIT_CYCLES 0 and 3) against a
// transaction-level model, plus directed literal expectations.
module tb_sram_read_port;

    localparam int WA = 0;
    localparam int WB = 3;
`ifdef SRAM_READ_REG_EN
    localparam int PHA = WA + 2;
    localparam int PHB = WB + 2;
`else
    localparam int PHA = WA + 1;
    localparam int PHB = WB + 1;
`endif

    logic        CLK = 1'b0;
    logic        RST;

    logic        req_a, clr_a, empty_a, done_a, ovr_a;
    logic        ce_a, oe_a, we_a, lb_a, ub_a;
    logic [21:1] addr_a, sa_a;
    logic [31:0] data_a;
    logic [15:0] dq_a;

    logic        req_b, clr_b, empty_b, done_b, ovr_b;
    logic        ce_b, oe_b, we_b, lb_b, ub_b;
    logic [21:1] addr_b, sa_b;
    logic [31:0] data_b;
    logic [15:0] dq_b;

    logic [15:0] mem [0:4095];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    assign dq_a = mem[sa_a[12:1]];
    assign dq_b = mem[sa_b[12:1]];

    sram_read_port #(.WAIT_CYCLES(WA)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .data_r_req(req_a), .data_r_address(addr_a),
        .data_r(data_a), .data_r_empty(empty_a), .data_r_done(done_a),
        .overrun(ovr_a), .overrun_clr(clr_a),
        .sram_a(sa_a), .sram_dq(dq_a),
        .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(we_a),
        .sram_lb_n(lb_a), .sram_ub_n(ub_a)
    );

    sram_read_port #(.WAIT_CYCLES(WB)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .data_r_req(req_b), .data_r_address(addr_b),
        .data_r(data_b), .data_r_empty(empty_b), .data_r_done(done_b),
        .overrun(ovr_b), .overrun_clr(clr_b),
        .sram_a(sa_b), .sram_dq(dq_b),
        .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(we_b),
        .sram_lb_n(lb_b), .sram_ub_n(ub_b)
    );

    // Model: a word in flight with a countdown of remaining cycles, a
    // one-entry pending slot, and the observable read-side results.
    typedef struct {
        bit          busy;
        int          left;
        logic [21:1] cur;
        bit          pv;
        logic [21:1] pa;
        bit          ovr;
        logic [31:0] data;
        bit          empty;
        bit          done;
        logic [21:1] last_a;
    } mst_t;

    mst_t ms_a, ms_b;

    function automatic logic [15:0] mv(logic [21:1] a);
        return mem[a[12:1]];
    endfunction

    function automatic mst_t mreset();
        mst_t s;
        s.busy = 0; s.left = 0; s.cur = '0; s.pv = 0; s.pa = '0;
        s.ovr = 0; s.data = '0; s.empty = 1; s.done = 0; s.last_a = '0;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, int ph, bit req, logic [21:1] a, bit clr);
        mst_t n;
        bit   set;
        n = s;
        set = 0;
        n.done = 0;
        if (s.busy) begin
            if (s.left == 1) begin
                n.data  = {mv({s.cur[21:2], 1'b1}), mv({s.cur[21:2], 1'b0})};
                n.empty = 0;
                n.done  = 1;
                if (s.pv) begin
                    n.cur  = s.pa;
                    n.left = 2 * ph;
                    n.pv   = req;
                    if (req) n.pa = a;
                end else if (req) begin
                    n.cur  = a;
                    n.left = 2 * ph;
                end else begin
                    n.busy   = 0;
                    n.last_a = {s.cur[21:2], 1'b1};
                end
            end else begin
                n.left = s.left - 1;
                if (req) begin
                    if (s.pv) set = 1;
                    n.pv = 1;
                    n.pa = a;
                end
            end
        end else if (req) begin
            n.busy = 1;
            n.cur  = a;
            n.left = 2 * ph;
        end
        if (set) n.ovr = 1;
        else if (clr) n.ovr = 0;
        return n;
    endfunction

    // Expected output vector: {pad, data, empty, done, ovr, sram_a, ce, oe, lb, ub, we}.
    function automatic logic [63:0] mexp(mst_t s, int ph);
        logic [21:1] a;
        bit          hi;
        if (s.busy) begin
            hi = ((2 * ph - s.left) >= ph);
            a  = {s.cur[21:2], hi};
        end else begin
            a = s.last_a;
        end
        return {3'b000, s.data, s.empty, s.done, s.ovr, a,
                !s.busy, !s.busy, !s.busy, !s.busy, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ms_a <= mreset();
            ms_b <= mreset();
        end else begin
            ms_a <= mstep(ms_a, PHA, req_a, addr_a, clr_a);
            ms_b <= mstep(ms_b, PHB, req_b, addr_b, clr_b);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        chk("cycle_a", {3'b000, data_a, empty_a, done_a, ovr_a, sa_a, ce_a, oe_a, lb_a, ub_a, we_a},
            mexp(ms_a, PHA));
        chk("cycle_b", {3'b000, data_b, empty_b, done_b, ovr_b, sa_b, ce_b, oe_b, lb_b, ub_b, we_b},
            mexp(ms_b, PHB));
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        RST = 1'b0;
        req_a = 0; clr_a = 0; addr_a = '0;
        req_b = 0; clr_b = 0; addr_b = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h104] = 16'h1234;
        mem[12'h105] = 16'hABCD;
        repeat (3) tick();
        chk("reset_data", 64'(data_a), 64'h0);
        chk("reset_empty", 64'(empty_a), 64'h1);
        chk("reset_strobes", 64'({ce_a, oe_a, we_a, lb_a, ub_a}), 64'h1F);
        chk("reset_sram_a", 64'(sa_a), 64'h0);
        RST = 1'b1;
        tick();

        // Abort a read in its high phase.
        req_a = 1; addr_a = 21'h00200;
        tick();
        req_a = 0;
        repeat (PHA) tick();
        chk("abort_in_hi", 64'(ce_a), 64'h0);
        #2 RST = 1'b0;
        #1;
        chk("abort_data", 64'(data_a), 64'h0);
        chk("abort_empty", 64'(empty_a), 64'h1);
        chk("abort_strobes", 64'({ce_a, oe_a, we_a, lb_a, ub_a}), 64'h1F);
        chk("abort_done", 64'(done_a), 64'h0);
        tick();
        chk("abort_done2", 64'(done_a), 64'h0);
        RST = 1'b1;
        tick();
        chk("abort_done3", 64'(done_a), 64'h0);
        chk("abort_idle", 64'(ce_a), 64'h1);

        // Single read of the word at halfwords 0x104/0x105.
        req_a = 1; addr_a = 21'h00105;
        tick();
        req_a = 0;
        for (int k = 0; k < PHA; k++) begin
            chk("single_lo_addr", 64'(sa_a), 64'h104);
            chk("single_lo_ce", 64'(ce_a), 64'h0);
            tick();
        end
        for (int k = 0; k < PHA; k++) begin
            chk("single_hi_addr", 64'(sa_a), 64'h105);
            chk("single_not_yet", 64'(data_a), 64'h0);
            chk("single_empty_still", 64'(empty_a), 64'h1);
            tick();
        end
        chk("single_data", 64'(data_a), 64'hABCD1234);
        chk("single_empty", 64'(empty_a), 64'h0);
        chk("single_done", 64'(done_a), 64'h1);
        tick();
        chk("single_done_pulse", 64'(done_a), 64'h0);
        chk("single_hold", 64'(data_a), 64'hABCD1234);
        repeat (4) tick();

        // Sustained stream of 256 aligned words.
        done_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            req_a = 1; addr_a = 21'(2 * k);
            tick();
            req_a = 0;
            chk("stream_no_idle", 64'(ce_a), 64'h0);
            if (done_a) done_cnt++;
            for (int j = 0; j < 2 * PHA - 1; j++) begin
                tick();
                chk("stream_no_idle", 64'(ce_a), 64'h0);
                if (done_a) done_cnt++;
            end
        end
        repeat (2 * PHA + 2) begin
            tick();
            if (done_a) done_cnt++;
        end
        chk("stream_done_count", 64'(done_cnt), 64'd256);
        chk("stream_overrun", 64'(ovr_a), 64'h0);
        chk("stream_last_word", 64'(data_a), 64'({mem[12'h1FF], mem[12'h1FE]}));

        // Pending slot plus a new request in the completion cycle.
        req_a = 1; addr_a = 21'h00060;
        tick();
        addr_a = 21'h00040;
        tick();
        req_a = 0;
        repeat (2 * PHA - 2) tick();
        req_a = 1; addr_a = 21'h00050;
        tick();
        req_a = 0;
        chk("pend_first", 64'(sa_a), 64'h40);
        chk("pend_ovr", 64'(ovr_a), 64'h0);
        repeat (2 * PHA) tick();
        chk("pend_second", 64'(sa_a), 64'h50);
        chk("pend_ovr2", 64'(ovr_a), 64'h0);
        repeat (2 * PHA + 2) tick();

        // Overrun on the slow instance: 0x20 is displaced by 0x30.
        req_b = 1; addr_b = 21'h00010;
        tick();
        addr_b = 21'h00020;
        tick();
        addr_b = 21'h00030;
        tick();
        req_b = 0;
        chk("ovr_set", 64'(ovr_b), 64'h1);
        repeat (2 * PHB - 2) tick();
        chk("ovr_next_word", 64'(sa_b), 64'h30);
        chk("ovr_sticky", 64'(ovr_b), 64'h1);
        chk("ovr_word_0x10", 64'(data_b), 64'({mem[12'h011], mem[12'h010]}));
        clr_b = 1;
        tick();
        clr_b = 0;
        chk("ovr_clr", 64'(ovr_b), 64'h0);
        req_b = 1; addr_b = 21'h00070;
        tick();
        addr_b = 21'h00080; clr_b = 1;
        tick();
        req_b = 0; clr_b = 0;
        chk("ovr_set_beats_clr", 64'(ovr_b), 64'h1);
        clr_b = 1;
        tick();
        clr_b = 0;
        chk("ovr_clr2", 64'(ovr_b), 64'h0);
        repeat (4 * PHB + 4) tick();
        chk("ovr_word_0x80", 64'(data_b), 64'({mem[12'h081], mem[12'h080]}));

        // Randomized traffic on both instances, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            req_a  = ($urandom_range(2) == 0);
            addr_a = 21'($urandom);
            clr_a  = ($urandom_range(15) == 0);
            req_b  = ($urandom_range(4) == 0);
            addr_b = 21'($urandom);
            clr_b  = ($urandom_range(15) == 0);
            if (i == 1500) begin
                RST = 1'b0;
                tick();
                RST = 1'b1;
            end
            tick();
        end
        req_a = 0; clr_a = 0; req_b = 0; clr_b = 0;
        repeat (4 * PHB + 4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_read_port.md
Name: sram_read_port

Overview:
- Read-side SRAM controller that serves the VGA sampler's 32-bit word requests (data_r_req / data_r_address / data_r / data_r_empty).
- Sits directly upstream of the sampler and drives the board's external 16-bit asynchronous SRAM.
- Each 32-bit word is built from two halfword reads. Back-to-back requests are sustained at one word per two cycles at default timing.

Parameters:
- WAIT_CYCLES, 0: extra cycles each halfword phase is held before capture (0..15).

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- data_r_req  input  1  read request, sampled every CLK edge
- data_r_address  input  [21:1]  halfword address of the request
- data_r  output  [31:0]  last completed word
- data_r_empty  output  1  high until the first word completes after reset
- data_r_done  output  1  one-cycle pulse on the cycle after data_r updates
- overrun  output  1  sticky flag: a pending request was overwritten
- overrun_clr  input  1  clears overrun
- sram_a  output  [21:1]  SRAM halfword address
- sram_dq  input  [15:0]  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  output  1 each  SRAM strobes

Behaviour:
- Reset values: data_r=0, data_r_empty=1, data_r_done=0, overrun=0, sram_a=0, all strobes=1, state IDLE, pending slot empty.
- Asserting RST mid-access aborts the access at once. No partial word is ever written to data_r.
- sram_we_n is held 1 at all times.
- States: IDLE, RD_LO, RD_HI.
- Each phase lasts P = WAIT_CYCLES+1 cycles, counted by a phase counter.
- RD_LO: sram_a={A[21:2],1'b0}; ce_n=oe_n=lb_n=ub_n=0. At the end of the phase's last cycle, sram_dq is captured into lo.
- RD_HI: sram_a={A[21:2],1'b1}; same strobes. At the end of the last cycle: data_r<={sram_dq,lo}; data_r_empty<=0; data_r_done=1 in the next cycle.
- Address bit A[1] is ignored; the word always covers the aligned halfword pair.
- IDLE: strobes=1, sram_a holds its last value. A request sampled in IDLE latches A and enters RD_LO next cycle.
- Latency at P=1: request sampled at edge t, data_r valid from cycle t+3.
- End of RD_HI (completion cycle), next request is chosen in this order:
  - pending slot full: go to RD_LO with the pending address; a req in the same cycle moves into pending.
  - else req asserted: go to RD_LO with req's address.
  - else go to IDLE.
- Request while busy and not in the completion cycle: stored in pending. If pending is already full, the address is replaced (newest wins) and overrun is set.
- overrun_clr and a new overrun event on the same edge: set wins.
- data_r holds its value between completions.

Optional Feature:
- Macro SRAM_READ_REG_EN.
- Defined: sram_dq is registered every cycle into dq_q; captures use dq_q; each phase lasts P+1 cycles; latency at WAIT_CYCLES=0 becomes 5 cycles; full throughput becomes one word per 4 cycles.
- Not defined: sram_dq is captured directly, with timing exactly as in Behaviour.

Test Plan:
- Reset: RST low mid-RD_HI → data_r unchanged (0), data_r_empty=1, all strobes=1, no data_r_done pulse.
- Single read: req with A=0x00105; SRAM model returns 0x1234 at 0x00104 and 0xABCD at 0x00105 → sram_a sequence 0x00104 then 0x00105; data_r=0xABCD1234 at t+3; data_r_empty falls to 0; one data_r_done pulse.
- Sustained stream: req every other cycle, addresses 0x0,0x2,...,0x1FE (256 words), WAIT_CYCLES=0 → no IDLE cycles between words, 256 done pulses, words match the model, overrun=0.
- Overrun: WAIT_CYCLES=3; three reqs A=0x10, 0x20, 0x30 on consecutive cycles → 0x10 serviced then 0x30; 0x20 dropped; overrun=1 until overrun_clr; clr on the same cycle as a new overrun leaves overrun=1.
- Pending and req at completion: pending=0x40 plus req 0x50 in the completion cycle → 0x40 serviced next, then 0x50, overrun stays 0.
- SRAM_READ_REG_EN build: single read at WAIT_CYCLES=0 → data_r valid at t+5, each phase is 2 cycles, same data as the unregistered build.
